// File: rtl/buffer_word_serializer_pkg.sv
// rtl/buffer_word_serializer_pkg.sv - shared word packing defaults and serializer state encoding
package buffer_word_serializer_pkg;

    localparam int WORD_W_DEF    = 16;
    localparam int NUM_WORDS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/buffer_word_serializer.sv
// rtl/buffer_word_serializer.sv - replays a captured packed buffer as a valid/ready word stream
module buffer_word_serializer
    import buffer_word_serializer_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        load,
    input  logic [WORD_W*NUM_WORDS-1:0] buffer_in,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [WORD_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_index,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done,
    output logic [WORD_W-1:0]           checksum,
    output logic                        overrun,
    input  logic                        clear_overrun
);

    localparam int               BUF_W    = WORD_W * NUM_WORDS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  checksum_q, checksum_d;
    logic               overrun_q, overrun_d;
    logic               accept;
    logic               xfer;

    // Word select straight out of the shadow register; the index, not a shift, walks the buffer.
    assign out_data  = shadow_q[idx_q*WORD_W +: WORD_W];
    assign out_index = idx_q;
    assign checksum  = checksum_q;
    assign overrun   = overrun_q;

    assign accept = (state_q == ST_IDLE) && load;
    assign xfer   = (state_q == ST_SEND) && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load) state_d = ST_SEND;
            ST_SEND: if (xfer && idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_SEND);
        out_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
        busy      = (state_q == ST_SEND) || (state_q == ST_DONE);
        done      = (state_q == ST_DONE);
    end

    always_comb begin
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        checksum_d = checksum_q;
        overrun_d  = overrun_q;
        if (accept) begin
            shadow_d   = buffer_in;
            idx_d      = '0;
            checksum_d = '0;
        end
        if (xfer) begin
            checksum_d = checksum_q + out_data;
            // The last index is held through DONE; wrap happens only via the next load.
            if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
        end
        if (clear_overrun) overrun_d = 1'b0;
        if (load && state_q != ST_IDLE) overrun_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q   <= '0;
            idx_q      <= '0;
            checksum_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
            checksum_q <= checksum_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_buffer_word_serializer.sv
// tb/tb_buffer_word_serializer.sv - randomized self-checking bench for buffer_word_serializer
module tb_buffer_word_serializer;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         load = 1'b0;
    logic [127:0] buffer_in = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [15:0]  out_data;
    logic [2:0]   out_index;
    logic         out_last;
    logic         busy;
    logic         done;
    logic [15:0]  checksum;
    logic         overrun;
    logic         clear_overrun = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    buffer_word_serializer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .load         (load),
        .buffer_in    (buffer_in),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum),
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
    );

    function automatic logic [127:0] rand_buf();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0: ready always 1; mode 1: ready 0,1,0,1...; mode 2: random ready.
    // ovr_at >= 0 issues a stray load while word ovr_at is presented (with clear if ovr_clr).
    task automatic run_stream(input logic [127:0] b, input int mode, input int ovr_at,
                              input bit ovr_clr, output int valid_cycles);
        logic [15:0] words[8];
        int          exp_sum;
        int          k;
        int          cyc;
        bit          rdy;
        bit          injected;
        for (int i = 0; i < 8; i++) words[i] = b[i*16 +: 16];
        @(negedge clock);
        load = 1'b1;
        buffer_in = b;
        out_ready = $urandom_range(0, 1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_latency: out_valid=%0b required 0 in load cycle", out_valid);
        end
        @(negedge clock);
        load = 1'b0;
        buffer_in = rand_buf();
        k = 0; cyc = 0; exp_sum = 0; valid_cycles = 0; injected = 0;
        while (k < 8 && cyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
            out_ready = rdy;
            load = 1'b0;
            clear_overrun = 1'b0;
            if (k == ovr_at && !injected) begin
                load = 1'b1;
                clear_overrun = ovr_clr;
                injected = 1;
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== words[k] || out_index !== 3'(k) ||
                out_last !== (k == 7) || busy !== 1'b1 || done !== 1'b0 ||
                checksum !== 16'(exp_sum)) begin
                n_fail++;
                $display("FAIL stream_word%0d: v=%0b d=%h i=%0d l=%0b b=%0b dn=%0b cs=%h required v=1 d=%h i=%0d l=%0b b=1 dn=0 cs=%h",
                         k, out_valid, out_data, out_index, out_last, busy, done, checksum,
                         words[k], k, (k == 7), 16'(exp_sum));
            end
            valid_cycles++;
            @(negedge clock);
            cyc++;
            if (rdy) begin
                exp_sum = (exp_sum + int'(words[k])) % 65536;
                k++;
            end
        end
        out_ready = $urandom_range(0, 1);
        load = 1'b0;
        clear_overrun = 1'b0;
        n_checks++;
        if (k < 8) begin
            n_fail++;
            $display("FAIL stream_timeout: words=%0d required 8", k);
        end
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 || checksum !== 16'(exp_sum)) begin
            n_fail++;
            $display("FAIL done_cycle: dn=%0b v=%0b b=%0b cs=%h required dn=1 v=0 b=1 cs=%h",
                     done, out_valid, busy, checksum, 16'(exp_sum));
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || checksum !== 16'(exp_sum)) begin
            n_fail++;
            $display("FAIL after_done: dn=%0b b=%0b v=%0b cs=%h required dn=0 b=0 v=0 cs=%h",
                     done, busy, out_valid, checksum, 16'(exp_sum));
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_index !== 3'd0 || out_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || checksum !== 16'h0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: v=%0b d=%h i=%0d l=%0b b=%0b dn=%0b cs=%h ov=%0b required all 0",
                     out_valid, out_data, out_index, out_last, busy, done, checksum, overrun);
        end
        reset_n = 1'b1;
    endtask

    function automatic logic [127:0] ramp_buf();
        logic [127:0] b;
        for (int i = 0; i < 8; i++) b[i*16 +: 16] = 16'(i);
        return b;
    endfunction

    task automatic test_ramp_full_rate();
        int vc;
        run_stream(ramp_buf(), 0, -1, 0, vc);
        n_checks++;
        if (vc !== 8 || checksum !== 16'd28) begin
            n_fail++;
            $display("FAIL ramp_full_rate: cycles=%0d cs=%0d required 8 and 28", vc, checksum);
        end
    endtask

    task automatic test_ramp_toggle_ready();
        int vc;
        run_stream(ramp_buf(), 1, -1, 0, vc);
        n_checks++;
        if (vc !== 16 || checksum !== 16'd28) begin
            n_fail++;
            $display("FAIL ramp_toggle: cycles=%0d cs=%0d required 16 and 28", vc, checksum);
        end
    endtask

    task automatic test_checksum_wrap();
        int vc;
        run_stream({8{16'hFFFF}}, 2, -1, 0, vc);
        n_checks++;
        if (checksum !== 16'hFFF8) begin
            n_fail++;
            $display("FAIL checksum_wrap: cs=%h required fff8", checksum);
        end
    endtask

    task automatic test_overrun();
        int vc;
        run_stream(rand_buf(), 0, 3, 0, vc);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: ov=%0b required 1", overrun);
        end
        clear_overrun = 1'b1;
        @(negedge clock);
        clear_overrun = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: ov=%0b required 0", overrun);
        end
        run_stream(rand_buf(), 2, 2, 1, vc);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set_wins: ov=%0b required 1", overrun);
        end
        clear_overrun = 1'b1;
        @(negedge clock);
        clear_overrun = 1'b0;
    endtask

    task automatic test_abort();
        int  cyc;
        int  vc;
        bit  seen_done;
        @(negedge clock);
        load = 1'b1;
        buffer_in = rand_buf();
        out_ready = 1'b1;
        @(negedge clock);
        load = 1'b0;
        cyc = 0;
        while (out_index !== 3'd5 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        n_checks++;
        if (cyc >= 50 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach5: idx=%0d v=%0b required idx 5 valid", out_index, out_valid);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_index !== 3'd0 || out_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || checksum !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_async: v=%0b d=%h i=%0d l=%0b b=%0b dn=%0b cs=%h required all 0",
                     out_valid, out_data, out_index, out_last, busy, done, checksum);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b0;
        seen_done = 0;
        repeat (3) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0 || checksum !== 16'h0) seen_done = 1;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL abort_no_done: dn=%0b b=%0b cs=%h required 0 0 0", done, busy, checksum);
        end
        run_stream(rand_buf(), 2, -1, 0, vc);
    endtask

    task automatic test_back_to_back();
        int vc;
        for (int n = 0; n < 6; n++) run_stream(rand_buf(), n % 3, -1, 0, vc);
    endtask

    initial begin
        test_reset();
        test_ramp_full_rate();
        test_ramp_toggle_ready();
        test_checksum_wrap();
        test_overrun();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
